// File: rtl/spi_slv_pkg.sv
// Shared types and helpers for the SPI slave responder.
// State encoding, word-length codes, CPOL/CPHA bit positions.
package spi_slv_pkg;

  typedef enum logic [1:0] {
    WAIT_CS = 2'd0,
    IDLE    = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [1:0] WL_8  = 2'b00;
  localparam logic [1:0] WL_16 = 2'b01;
  localparam logic [1:0] WL_24 = 2'b10;
  localparam logic [1:0] WL_32 = 2'b11;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  function automatic logic [5:0] word_bits(
    input logic [1:0] wl
  );
    logic [5:0] n;
    n = 6'd8;
    unique case (wl)
      WL_8:  n = 6'd8;
      WL_16: n = 6'd16;
      WL_24: n = 6'd24;
      WL_32: n = 6'd32;
      default: n = 6'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/spi_slv_sync.sv
// Multi-flop synchroniser with a history flop for edge detection.
// Ports: clk, rst_n (sync, active low), d in; q, rise, fall out.
module spi_slv_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] pipe;
  logic              hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe <= {STAGES{RST_VAL}};
      hist <= RST_VAL;
    end else begin
      pipe <= {pipe[STAGES-2:0], d};
      hist <= pipe[STAGES-1];
    end
  end

  assign q    = pipe[STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave: oversampled SCK/CS/MOSI, modes 0-3, 8..32-bit words.
// Ports: GCLK, NRST, SCK_i, CS_i, MOSI_i, MISO_o, spi_mode_i,
//   word_len_i, tx_data_i, tx_load_i, tx_ready_o, rx_data_o,
//   rx_valid_o, busy_o, frame_err_o, tx_underrun_o.
// Option SPI_SLAVE_RESPONDER_LOOPBACK_EN: echo last rx word on
//   an empty TX buffer instead of zeros.
module spi_slave_responder
  import spi_slv_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_WORD    = 32
) (
  input  logic                GCLK,
  input  logic                NRST,
  input  logic                SCK_i,
  input  logic                CS_i,
  input  logic                MOSI_i,
  output logic                MISO_o,
  input  logic [1:0]          spi_mode_i,
  input  logic [1:0]          word_len_i,
  input  logic [MAX_WORD-1:0] tx_data_i,
  input  logic                tx_load_i,
  output logic                tx_ready_o,
  output logic [MAX_WORD-1:0] rx_data_o,
  output logic                rx_valid_o,
  output logic                busy_o,
  output logic                frame_err_o,
  output logic                tx_underrun_o
);

  localparam int FW = $clog2(SYNC_STAGES + 2);
  localparam logic [FW-1:0] FLUSH = FW'(SYNC_STAGES + 1);

  state_e state;

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic mosi_q;

  logic [FW-1:0] flush;
  logic [1:0]    mode_q;
  logic [5:0]    nbits;
  logic [5:0]    bit_cnt;
  logic          first;
  logic [31:0]   sr_tx;
  logic [30:0]   sr_rx;
  logic [31:0]   rx_next;
  logic [31:0]   tx_buf;
  logic          tx_full;
  logic [31:0]   rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          underrun;

  logic sck_edge, lead, trail;
  logic do_sample, do_shift;
  logic [5:0] start_bits;
  logic [5:0] align;

  spi_slv_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sck (
    .clk  (GCLK),
    .rst_n(NRST),
    .d    (SCK_i),
    .q    (sck_q),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_slv_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs (
    .clk  (GCLK),
    .rst_n(NRST),
    .d    (CS_i),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  assign mosi_q = mosi_pipe[SYNC_STAGES-1];

  // After an edge, sck_q already holds the new level.
  assign sck_edge = sck_rise | sck_fall;
  assign lead  = sck_edge & (sck_q != mode_q[CPOL_BIT]);
  assign trail = sck_edge & (sck_q == mode_q[CPOL_BIT]);

  assign do_sample = mode_q[CPHA_BIT] ? trail : lead;
  assign do_shift  = mode_q[CPHA_BIT] ? (lead & ~first)
                                      : trail;

  assign rx_next = {sr_rx, mosi_q};

  // TX word is left-aligned so MISO always taps bit 31.
  assign start_bits = word_bits(word_len_i);
  assign align      = 6'd32 - start_bits;

  always_ff @(posedge GCLK) begin
    if (!NRST) begin
      state     <= WAIT_CS;
      mosi_pipe <= '0;
      flush     <= '0;
      mode_q    <= '0;
      nbits     <= 6'd8;
      bit_cnt   <= '0;
      first     <= 1'b0;
      sr_tx     <= '0;
      sr_rx     <= '0;
      tx_buf    <= '0;
      tx_full   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      underrun  <= 1'b0;
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI_i};
      unique case (state)
        WAIT_CS: begin
          // Let the synchronisers refill before trusting CS.
          if (flush != FLUSH) begin
            flush <= flush + 1'b1;
          end else if (cs_q) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (cs_fall) begin
            mode_q  <= spi_mode_i;
            nbits   <= start_bits;
            bit_cnt <= '0;
            first   <= 1'b1;
            sr_rx   <= '0;
            tx_full <= 1'b0;
            state   <= SHIFT;
            if (tx_full) begin
              sr_tx <= tx_buf << align;
            end else begin
`ifdef SPI_SLAVE_RESPONDER_LOOPBACK_EN
              sr_tx <= rx_data << align;
`else
              sr_tx    <= '0;
              underrun <= 1'b1;
`endif
            end
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            if (do_shift) sr_tx <= sr_tx << 1;
            if (lead) first <= 1'b0;
            if (do_sample) begin
              sr_rx   <= rx_next[30:0];
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == nbits - 6'd1) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                state    <= DONE;
              end
            end
          end
        end
        DONE: begin
          if (cs_rise) state <= IDLE;
        end
        default: state <= WAIT_CS;
      endcase
      // Runs after a frame start clears the buffer, so a
      // same-cycle load is kept for the next frame.
      if (tx_load_i && !tx_full) begin
        tx_full <= 1'b1;
        tx_buf  <= tx_data_i;
      end
    end
  end

  assign busy_o        = (state == SHIFT) || (state == DONE);
  assign MISO_o        = busy_o ? sr_tx[31] : 1'b0;
  assign tx_ready_o    = ~tx_full;
  assign rx_data_o     = rx_data;
  assign rx_valid_o    = rx_valid;
  assign frame_err_o   = frame_err;
  assign tx_underrun_o = underrun;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder acting as SPI master.
// Covers all modes, word sizes, abort, underrun and reset.
module tb_spi_slave_responder;

  localparam int HALF = 8;

  logic        gclk = 1'b0;
  logic        nrst = 1'b0;
  logic        sck  = 1'b0;
  logic        cs   = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [1:0]  spi_mode = 2'b00;
  logic [1:0]  word_len = 2'b00;
  logic [31:0] tx_data = '0;
  logic        tx_load = 1'b0;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        frame_err;
  logic        tx_underrun;

  int errs   = 0;
  int checks = 0;
  int nvalid = 0;
  int nferr  = 0;
  int nund   = 0;

  always #5 gclk = ~gclk;

  spi_slave_responder #(
    .SYNC_STAGES(2),
    .MAX_WORD   (32)
  ) dut (
    .GCLK         (gclk),
    .NRST         (nrst),
    .SCK_i        (sck),
    .CS_i         (cs),
    .MOSI_i       (mosi),
    .MISO_o       (miso),
    .spi_mode_i   (spi_mode),
    .word_len_i   (word_len),
    .tx_data_i    (tx_data),
    .tx_load_i    (tx_load),
    .tx_ready_o   (tx_ready),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .busy_o       (busy),
    .frame_err_o  (frame_err),
    .tx_underrun_o(tx_underrun)
  );

  always @(negedge gclk) begin
    if (rx_valid)    nvalid++;
    if (frame_err)   nferr++;
    if (tx_underrun) nund++;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge gclk);
  endtask

  task automatic load(input logic [31:0] d);
    tx_data = d;
    tx_load = 1'b1;
    wt(1);
    tx_load = 1'b0;
  endtask

  task automatic clk_bits(
    input  logic [1:0]  mode,
    input  int          n,
    input  logic [31:0] d,
    output logic [31:0] m
  );
    m = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!mode[0]) begin
        mosi = d[i];
        wt(HALF);
        sck = ~mode[1];
        m = {m[30:0], miso};
        wt(HALF);
        sck = mode[1];
      end else begin
        sck  = ~mode[1];
        mosi = d[i];
        wt(HALF);
        sck = mode[1];
        m = {m[30:0], miso};
        wt(HALF);
      end
    end
  endtask

  task automatic xfer(
    input  logic [1:0]  mode,
    input  logic [1:0]  wl,
    input  logic [31:0] d,
    output logic [31:0] m
  );
    spi_mode = mode;
    word_len = wl;
    sck = mode[1];
    wt(HALF);
    cs = 1'b0;
    wt(HALF);
    clk_bits(mode, (int'(wl) + 1) * 8, d, m);
    wt(HALF);
    cs = 1'b1;
    wt(2 * HALF);
  endtask

  logic [31:0] m;
  logic [31:0] mexp;
  int v0, u0, e0, uexp;

  initial begin
    wt(4);
    check("rst_miso", miso, 0);
    check("rst_rx", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_und", tx_underrun, 0);
    check("rst_ready", tx_ready, 1);
    nrst = 1'b1;
    wt(10);

    // Mode 0, 8 bits
    v0 = nvalid; u0 = nund;
    load(32'hA5);
    check("t1_ready_lo", tx_ready, 0);
    xfer(2'd0, 2'b00, 32'h3C, m);
    check("t1_miso", m, 32'hA5);
    check("t1_rx", rx_data, 32'h3C);
    check("t1_valid", nvalid - v0, 1);
    check("t1_ready", tx_ready, 1);
    check("t1_und", nund - u0, 0);
    check("t1_busy", busy, 0);

    // Mode 3, 32 bits; second load ignored
    v0 = nvalid;
    load(32'h12345678);
    load(32'hFFFFFFFF);
    xfer(2'd3, 2'b11, 32'hDEADBEEF, m);
    check("t2_miso", m, 32'h12345678);
    check("t2_rx", rx_data, 32'hDEADBEEF);
    check("t2_valid", nvalid - v0, 1);

    // Mode 1, 16 bits, empty buffer
`ifdef SPI_SLAVE_RESPONDER_LOOPBACK_EN
    mexp = 32'hBEEF; uexp = 0;
`else
    mexp = 32'h0;    uexp = 1;
`endif
    v0 = nvalid; u0 = nund;
    xfer(2'd1, 2'b01, 32'h0F0F, m);
    check("t3_miso", m, mexp);
    check("t3_und", nund - u0, uexp);
    check("t3_rx", rx_data, 32'h0F0F);
    check("t3_valid", nvalid - v0, 1);

    // Mode 2, aborted after 5 SCK edges
    v0 = nvalid; e0 = nferr;
    spi_mode = 2'd2;
    word_len = 2'b00;
    sck = 1'b1;
    wt(HALF);
    cs = 1'b0;
    wt(HALF);
    for (int i = 0; i < 5; i++) begin
      sck = ~sck;
      mosi = ~mosi;
      wt(HALF);
    end
    check("t4_busy_mid", busy, 1);
    cs = 1'b1;
    wt(2 * HALF);
    check("t4_ferr", nferr - e0, 1);
    check("t4_novalid", nvalid - v0, 0);
    check("t4_rx_keep", rx_data, 32'h0F0F);
    check("t4_busy", busy, 0);
    load(32'h7E);
    xfer(2'd2, 2'b00, 32'h81, m);
    check("t4b_rx", rx_data, 32'h81);
    check("t4b_miso", m, 32'h7E);
    check("t4b_valid", nvalid - v0, 1);

    // Reset in the middle of a 24-bit frame
    spi_mode = 2'd0;
    word_len = 2'b10;
    sck = 1'b0;
    wt(HALF);
    cs = 1'b0;
    wt(HALF);
    clk_bits(2'd0, 10, 32'h2AA, m);
    wt(2);
    nrst = 1'b0;
    wt(1);
    check("t5_miso", miso, 0);
    check("t5_rx", rx_data, 0);
    check("t5_valid", rx_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", tx_ready, 1);
    check("t5_ferr", frame_err, 0);
    check("t5_und", tx_underrun, 0);
    nrst = 1'b1;
    v0 = nvalid; e0 = nferr;
    clk_bits(2'd0, 14, 32'h1555, m);
    check("t5_busy_tail", busy, 0);
    check("t5_miso_tail", miso, 0);
    wt(HALF);
    cs = 1'b1;
    wt(2 * HALF);
    check("t5_novalid", nvalid - v0, 0);
    check("t5_noferr", nferr - e0, 0);
    load(32'h123456);
    xfer(2'd0, 2'b10, 32'hABCDEF, m);
    check("t5b_rx", rx_data, 32'hABCDEF);
    check("t5b_miso", m, 32'h123456);
    check("t5b_valid", nvalid - v0, 1);

    // Empty-buffer frame after a received word
    load(32'hC3);
    xfer(2'd0, 2'b00, 32'h5A, m);
    check("t6_miso", m, 32'hC3);
    check("t6_rx", rx_data, 32'h5A);
`ifdef SPI_SLAVE_RESPONDER_LOOPBACK_EN
    mexp = 32'h5A; uexp = 0;
`else
    mexp = 32'h0;  uexp = 1;
`endif
    u0 = nund;
    xfer(2'd0, 2'b00, 32'h99, m);
    check("t6b_miso", m, mexp);
    check("t6b_und", nund - u0, uexp);
    check("t6b_rx", rx_data, 32'h99);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI slave (responder) that sits at the far end of the SPI link driven by the team's SPI master controller.
- Serves as the bench/system counterpart of that master.
- Oversamples the incoming SCK, CS and MOSI on the system clock GCLK, supports all four SPI modes and 8/16/24/32-bit words, MSB first.
- Returns a preloaded TX word on MISO and presents each received word with a one-cycle valid pulse.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the SCK/CS/MOSI synchronisers (minimum 2).
- MAX_WORD, 32, width of the tx/rx data ports in bits; fixed at 32.

Ports:
- GCLK  in  1  system clock; all logic on rising edge.
- NRST  in  1  synchronous, active-low reset.
- SCK_i  in  1  SPI clock from master (asynchronous to GCLK).
- CS_i  in  1  chip select from master, active low.
- MOSI_i  in  1  serial data from master.
- MISO_o  out  1  serial data to master.
- spi_mode_i  in  2  bit1=CPOL, bit0=CPHA; sampled at frame start.
- word_len_i  in  2  00=8, 01=16, 10=24, 11=32 bits; sampled at frame start.
- tx_data_i  in  32  next word to transmit; bits [N-1:0] used.
- tx_load_i  in  1  load tx_data_i into the TX buffer; accepted only while tx_ready_o=1.
- tx_ready_o  out  1  TX buffer empty.
- rx_data_o  out  32  last received word, right-aligned, upper bits zero.
- rx_valid_o  out  1  one-cycle pulse when rx_data_o updates.
- busy_o  out  1  frame in progress.
- frame_err_o  out  1  one-cycle pulse when CS rises before N bits have been sampled.
- tx_underrun_o  out  1  one-cycle pulse when a frame starts with the TX buffer empty.

Behaviour:
- **Reset (NRST=0 at a GCLK edge):**
  - MISO_o=0, rx_data_o=0, rx_valid_o=0, busy_o=0, frame_err_o=0, tx_underrun_o=0.
  - TX buffer cleared, so tx_ready_o=1.
  - Synchronisers cleared to CS=1, SCK=0, MOSI=0.
  - State goes to WAIT_CS.
- **Synchronisation:** SCK, CS and MOSI each pass through SYNC_STAGES flops, followed by one history flop for edge detection.
  - Master SCK half-period must be at least SYNC_STAGES+2 GCLK cycles.
  - CS_SCK and SCK_CS setup/hold must be at least SYNC_STAGES+2 GCLK cycles.
- **Edge naming:** the leading edge is the SCK transition away from CPOL; the trailing edge is the transition back to CPOL.
- **State machine:**
  - WAIT_CS: stays here until synchronised CS=1, then goes to IDLE. Prevents a partial frame after reset mid-transfer.
  - IDLE: on a synchronised CS falling edge:
    - latch mode and N from spi_mode_i/word_len_i;
    - load the TX shift register from the buffer (or zeros if the buffer is empty, pulsing tx_underrun_o);
    - clear the buffer, clear the bit counter, go to SHIFT; busy_o=1 from the next cycle.
  - SHIFT:
    - Sample MOSI on the leading edge if CPHA=0, on the trailing edge if CPHA=1.
    - MISO_o shows shift register bit N-1 throughout.
    - CPHA=0: the first bit is valid from frame start; the register shifts on each trailing edge.
    - CPHA=1: the register shifts on each leading edge except the first; the first leading edge just presents bit N-1.
    - After the Nth sample, go to DONE.
    - If CS rises before the Nth sample: pulse frame_err_o, leave rx_data_o unchanged, go to IDLE.
  - DONE:
    - rx_data_o is written and rx_valid_o pulses in the cycle after the Nth sample (latency 1 GCLK from detection of the last sampling edge).
    - Further SCK edges are ignored until CS rises, then go to IDLE with busy_o=0.
    - One word per CS frame.
- **Outputs outside a frame:** MISO_o=0 whenever not in SHIFT/DONE.
- **TX load rules:**
  - tx_load_i is accepted only when tx_ready_o=1; loads while tx_ready_o=0 are ignored.
  - A load in the same cycle as frame start is stored for the next frame; the current frame sees an empty buffer and underruns.
- **Frame-parameter changes:** changes to spi_mode_i/word_len_i during a frame are ignored.

Optional Feature:
- Macro: SPI_SLAVE_RESPONDER_LOOPBACK_EN.
- Defined: when a frame starts with the TX buffer empty, the previously received rx_data_o[N-1:0] is transmitted instead of zeros, and tx_underrun_o does not pulse.
- Undefined: zeros are transmitted and tx_underrun_o pulses, as above.

Decomposition:
- Package spi_slv_pkg:
  - state enum {WAIT_CS, IDLE, SHIFT, DONE};
  - word-length codes;
  - function word_bits(word_len) returning 8/16/24/32;
  - CPOL/CPHA bit-index constants.
- Sub-module spi_slv_sync: parameterised synchroniser plus rise/fall edge detector, instantiated for SCK and CS. MOSI uses the synchroniser only.

Test Plan:
- Mode 0, word_len=00, tx_data_i=0xA5 loaded, master sends 0x3C → MISO bits 1,0,1,0,0,1,0,1; rx_data_o=0x0000003C; rx_valid_o high exactly one cycle; tx_ready_o returns to 1 after frame start.
- Mode 3, word_len=11, tx_data_i=0x12345678, master sends 0xDEADBEEF → master receives 0x12345678; rx_data_o=0xDEADBEEF.
- Mode 1, word_len=01, no tx_load, master sends 0x0F0F → MISO all 0; tx_underrun_o pulses at frame start; rx_data_o=0x00000F0F.
- Mode 2, word_len=00, CS raised after 5 SCK edges → frame_err_o pulse, no rx_valid_o; next 8-bit frame 0x81 received correctly.
- NRST low one cycle after 10 bits of a 24-bit frame with CS still low → all outputs at reset values; remaining SCK edges ignored until CS rises; next frame 0xABCDEF received correctly.
- With SPI_SLAVE_RESPONDER_LOOPBACK_EN: receive 0x5A, then a second 8-bit frame with no tx_load → MISO returns 0x5A and no tx_underrun_o pulse.
